// File: rtl/cgr_kmer_addr_gen_pkg.sv
// Shared constants and {x,y} address helpers for the CGR k-mer address generator.
package cgr_kmer_addr_gen_pkg;
  localparam int MAX_K = 16;

  typedef logic [MAX_K-1:0]   axis_t;
  typedef logic [2*MAX_K-1:0] addr_t;

  // Centre of the CGR square: MSB set, rest clear.
  function automatic axis_t cgr_centre(input int k);
    return axis_t'(1) << (k - 1);
  endfunction

  function automatic addr_t cgr_pack(input axis_t x, input axis_t y, input int k);
    return (addr_t'(x) << k) | addr_t'(y);
  endfunction

  function automatic axis_t cgr_unpack_x(input addr_t a, input int k);
    return axis_t'(a >> k);
  endfunction

  function automatic axis_t cgr_unpack_y(input addr_t a, input int k);
    return axis_t'(a) & ((axis_t'(1) << k) - axis_t'(1));
  endfunction
endpackage

// File: rtl/cgr_kmer_addr_gen_if.sv
// Symbol-in / address-out valid/ready bundle for the CGR address generator.
interface cgr_kmer_addr_gen_if #(parameter int K = 3);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_symbol;
  logic         in_first;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [2*K-1:0] out_addr;
  logic         out_last;

  modport master (
    output in_valid, in_symbol, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_addr, out_last
  );

  modport slave (
    input  in_valid, in_symbol, in_first, in_last, out_ready,
    output in_ready, out_valid, out_addr, out_last
  );
endinterface

// File: rtl/cgr_kmer_addr_gen_out_slice.sv
// One-entry valid/ready output register; a new load wins over a same-cycle drain.
module cgr_out_slice #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/cgr_kmer_addr_gen.sv
// Streaming CGR address generator: K-bit X/Y shift registers per read, decimated
// and optionally warm-up-gated emission into a 1-deep output register.
module cgr_kmer_addr_gen
  import cgr_kmer_addr_gen_pkg::*;
#(
  parameter int K       = 3,
  parameter int CNT_W   = 16,
  parameter int DECIM_W = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               i_cfg_en,
  input  logic [DECIM_W-1:0] i_cfg_decim,
  input  logic               i_cfg_warmup,
  cgr_kmer_addr_gen_if.slave bus,
  output logic               o_short_read,
  output logic [CNT_W-1:0]   o_sym_count
);
  localparam int FW = $clog2(K + 1);
  localparam logic [K-1:0] CENTRE = K'(cgr_centre(K));

  logic [K-1:0]       r_x, r_y;
  logic [FW-1:0]      r_fill;
  logic [DECIM_W-1:0] r_phase;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_short;

  logic               w_in_ready, w_acc, w_ok, w_emit, w_out_valid;
  logic [K-1:0]       w_base_x, w_base_y, w_x_nxt, w_y_nxt;
  logic [FW-1:0]      w_fill_base, w_fill_nxt;
  logic [DECIM_W-1:0] w_phase_base, w_phase_nxt;
  logic [CNT_W-1:0]   w_cnt_base, w_cnt_nxt;
  logic [2*K-1:0]     w_addr;
  logic [2*K:0]       w_slice_data;

  assign w_in_ready  = i_cfg_en & (~w_out_valid | bus.out_ready);
  assign bus.in_ready = w_in_ready;
  assign w_acc       = bus.in_valid & w_in_ready;

  // in_first restarts the read: every per-read quantity starts from its idle value.
  assign w_base_x     = bus.in_first ? CENTRE : r_x;
  assign w_base_y     = bus.in_first ? CENTRE : r_y;
  assign w_fill_base  = bus.in_first ? '0 : r_fill;
  assign w_phase_base = bus.in_first ? '0 : r_phase;
  assign w_cnt_base   = bus.in_first ? '0 : r_cnt;

  assign w_x_nxt = (w_base_x >> 1) | (K'(bus.in_symbol[1]) << (K - 1));
  assign w_y_nxt = (w_base_y >> 1) | (K'(bus.in_symbol[0]) << (K - 1));

  assign w_fill_nxt = (w_fill_base == FW'(K)) ? w_fill_base : w_fill_base + FW'(1);
  assign w_cnt_nxt  = (&w_cnt_base) ? w_cnt_base : w_cnt_base + CNT_W'(1);

  assign w_ok   = ~i_cfg_warmup | (w_fill_nxt >= FW'(K));
  assign w_emit = w_ok & ((w_phase_base >= i_cfg_decim) | bus.in_last);

  // Phase saturates so a long warm-up cannot wrap it below cfg_decim.
  assign w_phase_nxt = w_emit ? '0 :
                       (&w_phase_base) ? w_phase_base : w_phase_base + DECIM_W'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_x     <= CENTRE;
      r_y     <= CENTRE;
      r_fill  <= '0;
      r_phase <= '0;
      r_cnt   <= '0;
      r_short <= 1'b0;
    end else begin
      r_short <= w_acc & bus.in_last & ~w_ok;
      if (w_acc) begin
        r_x     <= w_x_nxt;
        r_y     <= w_y_nxt;
        r_fill  <= w_fill_nxt;
        r_phase <= w_phase_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end
  end

  assign w_addr = (2*K)'(cgr_pack(axis_t'(w_x_nxt), axis_t'(w_y_nxt), K));

  cgr_out_slice #(.W(2*K+1)) u_out (
    .CLK     (CLK),
    .RST     (RST),
    .i_load  (w_acc & w_emit),
    .i_data  ({w_addr, bus.in_last}),
    .i_ready (bus.out_ready),
    .o_valid (w_out_valid),
    .o_data  (w_slice_data)
  );

  assign bus.out_valid = w_out_valid;
  assign bus.out_addr  = w_slice_data[2*K:1];
  assign bus.out_last  = w_slice_data[0];
  assign o_short_read  = r_short;
  assign o_sym_count   = r_cnt;
endmodule

// File: tb/tb_cgr_kmer_addr_gen.sv
// Randomised and directed bench for cgr_kmer_addr_gen against a chaos-game reference model.
module tb_cgr_kmer_addr_gen;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cfg_en;
  logic [1:0]  cfg_decim;
  logic        cfg_warmup;
  logic        short_read;
  logic [15:0] sym_count;

  cgr_kmer_addr_gen_if #(.K(3)) bus();

  cgr_kmer_addr_gen #(.K(3), .CNT_W(16), .DECIM_W(2)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .i_cfg_en     (cfg_en),
    .i_cfg_decim  (cfg_decim),
    .i_cfg_warmup (cfg_warmup),
    .bus          (bus),
    .o_short_read (short_read),
    .o_sym_count  (sym_count)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: CGR point as integers, symbols since last emission, read length.
  int         mx, my, cnt, since, short_cnt;
  bit         exp_v, exp_l, exp_s;
  logic [5:0] exp_a;
  logic [6:0] got[$];

  always @(negedge CLK) begin
    if (RST) begin
      mx = 4; my = 4; cnt = 0; since = 0;
      exp_v = 0; exp_l = 0; exp_s = 0; exp_a = '0;
    end else begin
      bit acc, ok, emit;
      chk("out_valid", bus.out_valid, exp_v);
      if (exp_v) begin
        chk("out_addr", bus.out_addr, exp_a);
        chk("out_last", bus.out_last, exp_l);
      end
      chk("short_read", short_read, exp_s);
      chk("sym_count", sym_count, (cnt > 65535) ? 65535 : cnt);
      chk("in_ready", bus.in_ready, cfg_en & (~exp_v | bus.out_ready));
      if (short_read) short_cnt++;

      acc = bus.in_valid & cfg_en & (~exp_v | bus.out_ready);
      if (exp_v && bus.out_ready) begin
        got.push_back({bus.out_last, bus.out_addr});
        exp_v = 0;
      end
      exp_s = 0;
      if (acc) begin
        if (bus.in_first) begin
          mx = 4; my = 4; cnt = 0; since = 0;
        end
        mx = (mx >> 1) | (int'(bus.in_symbol[1]) << 2);
        my = (my >> 1) | (int'(bus.in_symbol[0]) << 2);
        cnt++;
        ok   = !cfg_warmup || cnt >= 3;
        emit = ok && (since >= int'(cfg_decim) || bus.in_last);
        if (emit) begin
          exp_v = 1; exp_a = 6'((mx << 3) | my); exp_l = bus.in_last; since = 0;
        end else begin
          since++;
        end
        if (bus.in_last && !ok) exp_s = 1;
      end
    end
  end

  task automatic send(input logic [1:0] s, input logic f, input logic l);
    bus.in_valid = 1'b1; bus.in_symbol = s; bus.in_first = f; bus.in_last = l;
    for (int t = 0; t < 60; t++) begin
      @(negedge CLK);
      if (bus.in_ready) begin
        @(posedge CLK); #1;
        return;
      end
      @(posedge CLK); #1;
    end
    n_checks++; n_fail++;
    $display("FAIL send_timeout: symbol never accepted, expected accept within 60 cycles");
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    cfg_en = 1; cfg_decim = 0; cfg_warmup = 0; short_cnt = 0;
    bus.in_valid = 0; bus.in_symbol = 0; bus.in_first = 0; bus.in_last = 0; bus.out_ready = 1;
    repeat (3) @(posedge CLK);
    #1 RST = 0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_addr", bus.out_addr, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_short", short_read, 0);
    chk("rst_sym_count", sym_count, 0);
    @(posedge CLK); #1;

    // 1: full-rate, every symbol emits
    got.delete();
    send(2'b11, 1, 0); send(2'b00, 0, 0); send(2'b10, 0, 0); idle(3);
    chk("t1_n", got.size(), 3);
    if (got.size() == 3) begin
      chk("t1_a0", got[0], 7'h36); chk("t1_a1", got[1], 7'h1B); chk("t1_a2", got[2], 7'h29);
    end

    // 2: warm-up hides the first K-1 points
    cfg_warmup = 1; got.delete();
    send(2'b11, 1, 0); send(2'b00, 0, 0); send(2'b10, 0, 1); idle(3);
    chk("t2_n", got.size(), 1);
    if (got.size() == 1) chk("t2_a0", got[0], 7'h69);

    // 3: decimation by two, then in_last forcing an extra emission
    cfg_warmup = 0; cfg_decim = 1; got.delete();
    send(2'b01, 1, 0);
    repeat (5) send(2'b01, 0, 0);
    idle(3);
    chk("t3_n", got.size(), 3);
    if (got.size() == 3) begin
      chk("t3_a0", got[0], 7'h0F); chk("t3_a1", got[1], 7'h07); chk("t3_last", got[2][6], 0);
    end
    got.delete();
    send(2'b01, 1, 0);
    repeat (3) send(2'b01, 0, 0);
    send(2'b01, 0, 1); send(2'b01, 0, 0); idle(3);
    chk("t3b_n", got.size(), 3);
    if (got.size() == 3) chk("t3b_last", got[2][6], 1);

    // 4: back-pressure holds the output and stalls input
    cfg_decim = 0; got.delete(); bus.out_ready = 0;
    bus.in_valid = 1; bus.in_symbol = 2'b11; bus.in_first = 1; bus.in_last = 0;
    @(posedge CLK); #1;
    bus.in_symbol = 2'b00; bus.in_first = 0;
    repeat (5) begin
      @(negedge CLK);
      chk("t4_in_ready", bus.in_ready, 0);
      chk("t4_hold", bus.out_addr, 6'h36);
    end
    @(posedge CLK); #1;
    bus.out_ready = 1;
    @(posedge CLK); #1;
    idle(3);
    chk("t4_n", got.size(), 2);
    if (got.size() == 2) begin
      chk("t4_a0", got[0], 7'h36); chk("t4_a1", got[1], 7'h1B);
    end
    chk("t4_cnt", sym_count, 2);

    // 5: short read under warm-up, then a clean restart
    cfg_warmup = 1; got.delete(); short_cnt = 0;
    send(2'b01, 1, 0); send(2'b10, 0, 1); idle(3);
    chk("t5_short", short_cnt, 1);
    chk("t5_n", got.size(), 0);
    send(2'b11, 1, 0); send(2'b00, 0, 0); send(2'b10, 0, 1); idle(3);
    chk("t5b_n", got.size(), 1);
    if (got.size() == 1) chk("t5b_a0", got[0], 7'h69);

    // 6: asynchronous reset discards a pending output
    cfg_warmup = 0; bus.out_ready = 0;
    send(2'b11, 1, 0);
    bus.in_valid = 0; bus.in_first = 0;
    chk("t6_pre_valid", bus.out_valid, 1);
    #1 RST = 1;
    #1;
    chk("t6_valid", bus.out_valid, 0);
    chk("t6_cnt", sym_count, 0);
    @(negedge CLK); #1 RST = 0;
    @(posedge CLK); #1;
    bus.out_ready = 1; got.delete();
    send(2'b01, 0, 0); idle(3);
    chk("t6_n", got.size(), 1);
    if (got.size() == 1) chk("t6_a0", got[0], 7'h16);

    // Random traffic checked cycle-by-cycle by the model
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        cfg_en     = ($urandom_range(0, 7) != 0);
        cfg_decim  = 2'($urandom);
        cfg_warmup = 1'($urandom);
      end
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_symbol = 2'($urandom);
      bus.in_first  = ($urandom_range(0, 7) == 0);
      bus.in_last   = ($urandom_range(0, 7) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge CLK); #1;
    end
    bus.out_ready = 1; cfg_en = 1;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
